// File: rtl/cart_loader.sv
// cart_loader: steers the console CPU RAM port between HPS cartridge downloads
// and the CPU, tracks the loaded image size, pads the unloaded remainder with a
// constant byte, mirrors or write-protects the image, and holds the console in
// reset for a fixed time after any reset, load or fill.
//
// Handshake: ioctl_wr is a single-cycle write strobe with no backpressure; a
// strobe is consumed in the cycle it is seen (LOAD state with an accepted
// download active) and is never stalled. CPU requests likewise complete in the
// cycle they are presented.
`timescale 1ns/1ps
module cart_loader #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned CART_INDEX = 1,
  parameter int unsigned RESET_HOLD = 255,
  parameter bit          FILL_EN    = 1'b1,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF,
  parameter bit          MIRROR     = 1'b1,
  parameter bit          WRITE_PROT = 1'b0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic              cpu_we_n,
  input  logic [7:0]        cpu_d,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_we,
  output logic [7:0]        ram_d,
  output logic              core_reset,
  output logic              busy,
  output logic              cart_valid,
  output logic [ADDR_W:0]   cart_size,
  output logic              overflow,
  output logic [1:0]        dbg_state_o
);

  localparam int unsigned CNT_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);
  localparam logic [ADDR_W:0] FULL    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] TOP_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_HOLD = 2'd0, S_RUN = 2'd1, S_LOAD = 2'd2, S_FILL = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [ADDR_W:0]   top_q, top_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] mask_q, mask_d;
  logic [ADDR_W:0]   cart_size_q, cart_size_d;
  logic              cart_valid_q, cart_valid_d;
  logic              overflow_q, overflow_d;

  logic              dl_acc;
  logic              in_range;
  logic [ADDR_W:0]   wr_end;
  logic [ADDR_W:0]   smear;
  logic [ADDR_W-1:0] mask_calc;
  logic [ADDR_W-1:0] cpu_masked;
  logic              enter_hold;
  logic              unused_bits;

  assign dl_acc     = ioctl_download && (ioctl_index[5:0] == 6'(CART_INDEX));
  assign in_range   = (ioctl_addr[24:ADDR_W] == '0);
  // Out-of-range writes saturate the size at the full RAM depth.
  assign wr_end     = in_range ? ({1'b0, ioctl_addr[ADDR_W-1:0]} + TOP_ONE) : FULL;
  assign cpu_masked = cpu_a & mask_q;
  assign unused_bits = ^{ioctl_index[7:6], smear[ADDR_W]};

  // Mirror mask: smallest power of two covering the image, minus one.
  always_comb begin
    smear = top_q - TOP_ONE;
    for (int i = 0; i < int'(ADDR_W); i++) smear = smear | (smear >> 1);
    mask_calc = (!MIRROR || top_q == '0) ? '1 : smear[ADDR_W-1:0];
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= CNT_W'(RESET_HOLD);
      top_q        <= '0;
      ptr_q        <= '0;
      mask_q       <= '1;
      cart_size_q  <= '0;
      cart_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      top_q        <= top_d;
      ptr_q        <= ptr_d;
      mask_q       <= mask_d;
      cart_size_q  <= cart_size_d;
      cart_valid_q <= cart_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state logic: a new accepted download preempts every other state.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    top_d        = top_q;
    ptr_d        = ptr_q;
    mask_d       = mask_q;
    cart_size_d  = cart_size_q;
    cart_valid_d = cart_valid_q;
    overflow_d   = overflow_q;
    enter_hold   = 1'b0;
    if (dl_acc && state_q != S_LOAD) begin
      state_d      = S_LOAD;
      top_d        = '0;
      overflow_d   = 1'b0;
      cart_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (dl_acc) begin
            if (ioctl_wr) begin
              if (!in_range) overflow_d = 1'b1;
              if (wr_end > top_q) top_d = wr_end;
            end
          end else if (FILL_EN && top_q < FULL) begin
            state_d = S_FILL;
            ptr_d   = top_q[ADDR_W-1:0];
          end else begin
            enter_hold = 1'b1;
          end
        end
        S_FILL: begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (&ptr_q) enter_hold = 1'b1;
        end
        S_HOLD: begin
          if (hold_cnt_q == '0) state_d = S_RUN;
          else                  hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
      if (enter_hold) begin
        state_d      = S_HOLD;
        hold_cnt_d   = CNT_W'(RESET_HOLD);
        cart_size_d  = top_q;
        cart_valid_d = (top_q != '0);
        mask_d       = mask_calc;
      end
    end
  end

  // Output logic: RAM port steering and status, decoded from registered state.
  always_comb begin
    ram_a      = cpu_masked;
    ram_d      = cpu_d;
    ram_we     = 1'b0;
    core_reset = (state_q != S_RUN);
    busy       = (state_q == S_LOAD) || (state_q == S_FILL);
    case (state_q)
      S_LOAD: begin
        ram_a  = ioctl_addr[ADDR_W-1:0];
        ram_d  = ioctl_dout;
        ram_we = dl_acc && ioctl_wr && in_range;
      end
      S_FILL: begin
        ram_a  = ptr_q;
        ram_d  = FILL_BYTE;
        ram_we = 1'b1;
      end
      S_RUN: begin
        ram_we = !cpu_we_n && !(WRITE_PROT && ({1'b0, cpu_masked} < cart_size_q));
      end
      default: ;
    endcase
  end

  assign cart_valid  = cart_valid_q;
  assign cart_size   = cart_size_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule
